// File: rtl/dma_psdpram_rd_arb_if.sv
// Segmented DMA RAM read bus: per-channel, per-segment command and pipelined response.
// CH channels are packed channel-major, then segment.
interface dma_psdpram_rd_arb_if #(
    parameter int CH             = 1,
    parameter int SEG_COUNT      = 2,
    parameter int SEG_DATA_WIDTH = 128,
    parameter int SEG_ADDR_WIDTH = 8
);
    logic [CH*SEG_COUNT*SEG_ADDR_WIDTH-1:0] cmd_addr;
    logic [CH*SEG_COUNT-1:0]                cmd_valid;
    logic [CH*SEG_COUNT-1:0]                cmd_ready;
    logic [CH*SEG_COUNT*SEG_DATA_WIDTH-1:0] resp_data;
    logic [CH*SEG_COUNT-1:0]                resp_valid;
    logic [CH*SEG_COUNT-1:0]                resp_ready;

    modport master (
        output cmd_addr, cmd_valid, resp_ready,
        input  cmd_ready, resp_data, resp_valid
    );

    modport slave (
        input  cmd_addr, cmd_valid, resp_ready,
        output cmd_ready, resp_data, resp_valid
    );
endinterface

// File: rtl/dma_psdpram_rd_arb.sv
// Per-segment round-robin arbiter sharing one segmented RAM read port between PORTS requesters.
// A per-segment tag FIFO steers in-order RAM responses back to the port that issued each read.
module dma_psdpram_rd_arb #(
    parameter int PORTS          = 2,
    parameter int SEG_COUNT      = 2,
    parameter int SEG_DATA_WIDTH = 128,
    parameter int SEG_ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int CL_PORTS       = $clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_psdpram_rd_arb_if.slave   s_rd,
    dma_psdpram_rd_arb_if.master  m_rd
);
    localparam int AW = SEG_ADDR_WIDTH;
    localparam int DW = SEG_DATA_WIDTH;
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_INC   = {{(PW-1){1'b0}}, 1'b1};

    for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
        logic [CL_PORTS-1:0] last_grant_q, last_grant_d;
        logic [CL_PORTS-1:0] lock_port_q, lock_port_d;
        logic                lock_q, lock_d;
        logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CL_PORTS-1:0] fifo_q [FIFO_DEPTH];
        logic [CL_PORTS-1:0] fifo_d [FIFO_DEPTH];
        logic [PORTS-1:0]    req_s, port_resp_ready_s;
        logic [CL_PORTS-1:0] grant_s, head_s;
        logic [AW-1:0]       addr_s;
        logic                full_s, empty_s, cmd_valid_s, resp_ready_s, resp_fwd_s;
        logic                push_s, pop_s;
        int                  idx_s;

        always_comb begin
            req_s             = '0;
            port_resp_ready_s = '0;
            for (int p = 0; p < PORTS; p++) begin
                req_s[p]             = s_rd.cmd_valid[p*SEG_COUNT+n];
                port_resp_ready_s[p] = s_rd.resp_ready[p*SEG_COUNT+n];
            end
        end

        // Locked grant holds a stalled command; otherwise scan from last_grant+1, nearest requester wins.
        always_comb begin
            grant_s = last_grant_q;
            idx_s   = 0;
            if (lock_q) begin
                grant_s = lock_port_q;
            end else begin
                for (int i = PORTS; i >= 1; i--) begin
                    idx_s   = (int'(last_grant_q) + i) % PORTS;
                    grant_s = req_s[idx_s] ? idx_s[CL_PORTS-1:0] : grant_s;
                end
            end
        end

        always_comb begin
            addr_s = '0;
            for (int p = 0; p < PORTS; p++) begin
                addr_s = (grant_s == CL_PORTS'(p)) ? s_rd.cmd_addr[(p*SEG_COUNT+n)*AW +: AW] : addr_s;
            end
        end

        assign full_s       = (wr_ptr_q - rd_ptr_q) == DEPTH_CNT;
        assign empty_s      = (wr_ptr_q == rd_ptr_q);
        assign head_s       = fifo_q[rd_ptr_q[IW-1:0]];
        assign cmd_valid_s  = rst_n & (lock_q | (|req_s)) & ~full_s;
        assign push_s       = cmd_valid_s & m_rd.cmd_ready[n];
        assign resp_ready_s = rst_n & ~empty_s & port_resp_ready_s[head_s];
        assign resp_fwd_s   = rst_n & m_rd.resp_valid[n] & ~empty_s;
        assign pop_s        = m_rd.resp_valid[n] & resp_ready_s;

        // Next-state: push/advance grant on handshake, lock on stall, pop on response handshake.
        always_comb begin
            last_grant_d = last_grant_q;
            lock_d       = lock_q;
            lock_port_d  = lock_port_q;
            wr_ptr_d     = wr_ptr_q;
            rd_ptr_d     = rd_ptr_q;
            fifo_d       = fifo_q;
            if (push_s) begin
                fifo_d[wr_ptr_q[IW-1:0]] = grant_s;
                wr_ptr_d                 = wr_ptr_q + PTR_INC;
                last_grant_d             = grant_s;
                lock_d                   = 1'b0;
            end else if (cmd_valid_s) begin
                lock_d      = 1'b1;
                lock_port_d = grant_s;
            end else begin
                lock_d = lock_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_INC;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last_grant_q <= CL_PORTS'(PORTS - 1);
                lock_q       <= 1'b0;
                lock_port_q  <= '0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                fifo_q       <= '{default: '0};
            end else begin
                last_grant_q <= last_grant_d;
                lock_q       <= lock_d;
                lock_port_q  <= lock_port_d;
                wr_ptr_q     <= wr_ptr_d;
                rd_ptr_q     <= rd_ptr_d;
                fifo_q       <= fifo_d;
            end
        end

        assign m_rd.cmd_valid[n]          = cmd_valid_s;
        assign m_rd.cmd_addr[n*AW +: AW]  = addr_s;
        assign m_rd.resp_ready[n]         = resp_ready_s;

        for (genvar p = 0; p < PORTS; p++) begin : g_port
            assign s_rd.cmd_ready[p*SEG_COUNT+n]  = rst_n & m_rd.cmd_ready[n] & ~full_s
                                                    & (grant_s == CL_PORTS'(p));
            assign s_rd.resp_valid[p*SEG_COUNT+n] = resp_fwd_s & (head_s == CL_PORTS'(p));
            assign s_rd.resp_data[(p*SEG_COUNT+n)*DW +: DW] = m_rd.resp_data[n*DW +: DW];
        end
    end
endmodule

// File: tb/tb_dma_psdpram_rd_arb.sv
// Directed bench for dma_psdpram_rd_arb: 2 ports, 2 segments, 4-deep tag FIFO, 2-cycle RAM model.
module tb_dma_psdpram_rd_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_psdpram_rd_arb_if #(.CH(2), .SEG_COUNT(2), .SEG_DATA_WIDTH(128), .SEG_ADDR_WIDTH(8)) s_rd ();
    dma_psdpram_rd_arb_if #(.CH(1), .SEG_COUNT(2), .SEG_DATA_WIDTH(128), .SEG_ADDR_WIDTH(8)) m_rd ();

    dma_psdpram_rd_arb #(
        .PORTS(2), .SEG_COUNT(2), .SEG_DATA_WIDTH(128), .SEG_ADDR_WIDTH(8), .FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_rd  (s_rd),
        .m_rd  (m_rd)
    );

    // RAM model per segment: response appears two cycles after issue, data = {A5.., addr}.
    for (genvar s = 0; s < 2; s++) begin : g_ram
        logic [7:0]   aq[$];
        int           tq[$];
        logic         vld_r;
        logic [127:0] dat_r;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                aq.delete();
                tq.delete();
                vld_r <= 1'b0;
                dat_r <= '0;
            end else begin
                if (m_rd.resp_valid[s] && m_rd.resp_ready[s] && aq.size() > 0) begin
                    void'(aq.pop_front());
                    void'(tq.pop_front());
                end
                if (m_rd.cmd_valid[s] && m_rd.cmd_ready[s]) begin
                    aq.push_back(m_rd.cmd_addr[s*8 +: 8]);
                    tq.push_back(cyc + 1);
                end
                if (aq.size() > 0 && tq[0] <= cyc) begin
                    vld_r <= 1'b1;
                    dat_r <= {{15{8'hA5}}, aq[0]};
                end else begin
                    vld_r <= 1'b0;
                end
            end
        end
        assign m_rd.resp_valid[s]            = vld_r;
        assign m_rd.resp_data[s*128 +: 128]  = dat_r;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input int n, input logic [7:0] a);
        s_rd.cmd_addr[(p*2+n)*8 +: 8] = a;
    endtask

    task automatic do_reset();
        s_rd.cmd_valid  = 4'b0000;
        s_rd.cmd_addr   = 32'h0;
        s_rd.resp_ready = 4'b1111;
        m_rd.cmd_ready  = 2'b11;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_rd.cmd_valid  = 4'b1111;
        s_rd.cmd_addr   = 32'h0;
        s_rd.resp_ready = 4'b1111;
        m_rd.cmd_ready  = 2'b11;
        #2;
        n_checks++;
        if ({m_rd.cmd_valid, s_rd.cmd_ready, s_rd.resp_valid, m_rd.resp_ready} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {m_rd.cmd_valid, s_rd.cmd_ready, s_rd.resp_valid, m_rd.resp_ready});
        end
        #5;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (m_rd.cmd_valid !== 2'b11) begin
            n_fail++; $display("FAIL reset_release_valid: got %b want 11", m_rd.cmd_valid);
        end
        n_checks++;
        if (s_rd.cmd_ready !== 4'b0011) begin
            n_fail++; $display("FAIL reset_first_grant: got %b want 0011", s_rd.cmd_ready);
        end
        s_rd.cmd_valid = 4'b0000;
    endtask

    task automatic test_single();
        logic [127:0] exp_d;
        exp_d = {{15{8'hA5}}, 8'h12};
        do_reset();
        step();
        set_addr(0, 0, 8'h12);
        s_rd.cmd_valid = 4'b0001;
        #1;
        n_checks++;
        if ({m_rd.cmd_valid[0], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0]} !== {1'b1, 1'b1, 8'h12}) begin
            n_fail++; $display("FAIL single_cmd: got v=%b r=%b a=%h want 1 1 12", m_rd.cmd_valid[0], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0]);
        end
        step();
        s_rd.cmd_valid = 4'b0000;
        #1;
        n_checks++;
        if (s_rd.resp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_early_resp: got %b want 0000", s_rd.resp_valid);
        end
        step();
        n_checks++;
        if ({s_rd.resp_valid[2], s_rd.resp_valid[0]} !== 2'b01) begin
            n_fail++; $display("FAIL single_resp_route: got p1=%b p0=%b want 0 1", s_rd.resp_valid[2], s_rd.resp_valid[0]);
        end
        n_checks++;
        if (s_rd.resp_data[127:0] !== exp_d || s_rd.resp_data[2*128 +: 128] !== exp_d) begin
            n_fail++; $display("FAIL single_resp_data: got %h want %h", s_rd.resp_data[127:0], exp_d);
        end
        step();
        n_checks++;
        if (s_rd.resp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_resp_pop: got %b want 0000", s_rd.resp_valid);
        end
    endtask

    task automatic test_round_robin();
        int k0, k1, ep, rp;
        logic [7:0] ea, ra;
        k0 = 0;
        k1 = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            set_addr(0, 0, 8'h10 + 8'(k0));
            set_addr(1, 0, 8'h20 + 8'(k1));
            s_rd.cmd_valid = (i < 8) ? 4'b0101 : 4'b0000;
            #1;
            if (i < 8) begin
                ep = i % 2;
                ea = ((ep == 1) ? 8'h20 : 8'h10) + 8'(i / 2);
                n_checks++;
                if ({s_rd.cmd_ready[2], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0]} !== {(ep == 1), (ep == 0), ea}) begin
                    n_fail++; $display("FAIL rr_grant_%0d: got r1=%b r0=%b a=%h want port %0d a=%h", i, s_rd.cmd_ready[2], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0], ep, ea);
                end
            end
            if (i >= 2) begin
                rp = (i - 2) % 2;
                ra = ((rp == 1) ? 8'h20 : 8'h10) + 8'((i - 2) / 2);
                n_checks++;
                if ({s_rd.resp_valid[2], s_rd.resp_valid[0], s_rd.resp_data[rp*256 +: 8]} !== {(rp == 1), (rp == 0), ra}) begin
                    n_fail++; $display("FAIL rr_resp_%0d: got v1=%b v0=%b d=%h want port %0d d=%h", i, s_rd.resp_valid[2], s_rd.resp_valid[0], s_rd.resp_data[rp*256 +: 8], rp, ra);
                end
            end
            if (s_rd.cmd_valid[0] && s_rd.cmd_ready[0]) k0++;
            if (s_rd.cmd_valid[2] && s_rd.cmd_ready[2]) k1++;
        end
    endtask

    task automatic test_fifo_full();
        int k;
        logic exp_v;
        k = 0;
        do_reset();
        s_rd.resp_ready = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step();
            set_addr(0, 0, 8'h40 + 8'(k));
            s_rd.cmd_valid = 4'b0001;
            #1;
            exp_v = (i < 4);
            n_checks++;
            if ({m_rd.cmd_valid[0], s_rd.cmd_ready[0]} !== {exp_v, exp_v}) begin
                n_fail++; $display("FAIL full_issue_%0d: got v=%b r=%b want %b", i, m_rd.cmd_valid[0], s_rd.cmd_ready[0], exp_v);
            end
            if (s_rd.cmd_ready[0]) k++;
        end
        n_checks++;
        if (k !== 4) begin
            n_fail++; $display("FAIL full_accept_count: got %0d want 4", k);
        end
        step();
        s_rd.resp_ready = 4'b0001;
        #1;
        n_checks++;
        if ({m_rd.cmd_valid[0], m_rd.resp_ready[0], s_rd.resp_valid[0]} !== 3'b011) begin
            n_fail++; $display("FAIL full_pop_cycle: got cv=%b rr=%b rv=%b want 0 1 1", m_rd.cmd_valid[0], m_rd.resp_ready[0], s_rd.resp_valid[0]);
        end
        step();
        s_rd.resp_ready = 4'b0000;
        #1;
        n_checks++;
        if ({m_rd.cmd_valid[0], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0]} !== {1'b1, 1'b1, 8'h44}) begin
            n_fail++; $display("FAIL full_reissue: got v=%b r=%b a=%h want 1 1 44", m_rd.cmd_valid[0], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0]);
        end
        step();
        set_addr(0, 0, 8'h45);
        #1;
        n_checks++;
        if (m_rd.cmd_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL full_again: got %b want 0", m_rd.cmd_valid[0]);
        end
        s_rd.cmd_valid = 4'b0000;
    endtask

    task automatic test_stall_lock();
        do_reset();
        m_rd.cmd_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            set_addr(1, 0, 8'h31);
            set_addr(0, 0, 8'h05);
            s_rd.cmd_valid = (i == 0) ? 4'b0100 : 4'b0101;
            #1;
            n_checks++;
            if ({m_rd.cmd_valid[0], m_rd.cmd_addr[7:0], s_rd.cmd_ready[2], s_rd.cmd_ready[0]} !== {1'b1, 8'h31, 2'b00}) begin
                n_fail++; $display("FAIL stall_hold_%0d: got v=%b a=%h r1=%b r0=%b want 1 31 0 0", i, m_rd.cmd_valid[0], m_rd.cmd_addr[7:0], s_rd.cmd_ready[2], s_rd.cmd_ready[0]);
            end
        end
        step();
        m_rd.cmd_ready = 2'b11;
        #1;
        n_checks++;
        if ({m_rd.cmd_addr[7:0], s_rd.cmd_ready[2], s_rd.cmd_ready[0]} !== {8'h31, 2'b10}) begin
            n_fail++; $display("FAIL stall_release: got a=%h r1=%b r0=%b want 31 1 0", m_rd.cmd_addr[7:0], s_rd.cmd_ready[2], s_rd.cmd_ready[0]);
        end
        step();
        s_rd.cmd_valid = 4'b0001;
        #1;
        n_checks++;
        if ({m_rd.cmd_addr[7:0], s_rd.cmd_ready[2], s_rd.cmd_ready[0]} !== {8'h05, 2'b01}) begin
            n_fail++; $display("FAIL stall_next: got a=%h r1=%b r0=%b want 05 0 1", m_rd.cmd_addr[7:0], s_rd.cmd_ready[2], s_rd.cmd_ready[0]);
        end
        step();
        s_rd.cmd_valid = 4'b0000;
    endtask

    task automatic test_seg_independence();
        do_reset();
        step();
        set_addr(0, 0, 8'h44);
        set_addr(1, 1, 8'h55);
        s_rd.cmd_valid = 4'b1001;
        #1;
        n_checks++;
        if ({m_rd.cmd_valid, m_rd.cmd_addr, s_rd.cmd_ready} !== {2'b11, 8'h55, 8'h44, 4'b1001}) begin
            n_fail++; $display("FAIL seg_issue: got v=%b a=%h r=%b want 11 5544 1001", m_rd.cmd_valid, m_rd.cmd_addr, s_rd.cmd_ready);
        end
        step();
        s_rd.cmd_valid = 4'b0000;
        #1;
        n_checks++;
        if (m_rd.resp_ready !== 2'b11) begin
            n_fail++; $display("FAIL seg_occupied: got %b want 11", m_rd.resp_ready);
        end
        step();
        n_checks++;
        if ({s_rd.resp_valid, s_rd.resp_data[7:0], s_rd.resp_data[3*128 +: 8]} !== {4'b1001, 8'h44, 8'h55}) begin
            n_fail++; $display("FAIL seg_resp: got v=%b d0=%h d3=%h want 1001 44 55", s_rd.resp_valid, s_rd.resp_data[7:0], s_rd.resp_data[3*128 +: 8]);
        end
        step();
        n_checks++;
        if (m_rd.resp_ready !== 2'b00) begin
            n_fail++; $display("FAIL seg_one_tag: got %b want 00", m_rd.resp_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_rd.resp_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            set_addr(0, 0, 8'h60 + 8'(i));
            s_rd.cmd_valid = 4'b0001;
        end
        step();
        set_addr(0, 0, 8'h63);
        set_addr(1, 0, 8'h70);
        s_rd.cmd_valid  = 4'b0101;
        s_rd.resp_ready = 4'b1111;
        #1;
        n_checks++;
        if (m_rd.resp_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL mid_outstanding: got %b want 1", m_rd.resp_ready[0]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_rd.cmd_valid, s_rd.cmd_ready, s_rd.resp_valid, m_rd.resp_ready} !== 10'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b want 0", {m_rd.cmd_valid, s_rd.cmd_ready, s_rd.resp_valid, m_rd.resp_ready});
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (m_rd.resp_ready !== 2'b00) begin
            n_fail++; $display("FAIL mid_fifo_empty: got %b want 00", m_rd.resp_ready);
        end
        n_checks++;
        if ({s_rd.cmd_ready[2], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0]} !== {2'b01, 8'h63}) begin
            n_fail++; $display("FAIL mid_first_grant: got r1=%b r0=%b a=%h want 0 1 63", s_rd.cmd_ready[2], s_rd.cmd_ready[0], m_rd.cmd_addr[7:0]);
        end
        step();
        s_rd.cmd_valid = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish before 100000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_stall_lock();
        test_seg_independence();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
